// File: rtl/out_port_fifo_if.sv
// Handshake bundle between the CPU OUT port, the output FIFO and the downstream consumer.
// With OUT_PORT_FIFO_STATS_EN defined the bundle also carries the 16-bit drop counter.
interface out_port_fifo_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 3
);
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              clr_ovf;
`ifdef OUT_PORT_FIFO_STATS_EN
  logic [15:0]       drop_cnt;
`endif

  modport master (
    output wr_en, wr_data, out_ready, clr_ovf,
    input  out_valid, out_data, full, empty, count, overflow
`ifdef OUT_PORT_FIFO_STATS_EN
    , input drop_cnt
`endif
  );

  modport slave (
    input  wr_en, wr_data, out_ready, clr_ovf,
    output out_valid, out_data, full, empty, count, overflow
`ifdef OUT_PORT_FIFO_STATS_EN
    , output drop_cnt
`endif
  );
endinterface

// File: rtl/out_port_fifo.sv
// First-word-fall-through FIFO buffering CPU OUT-port writes for a valid/ready consumer.
// Optional feature macro: OUT_PORT_FIFO_STATS_EN adds a saturating 16-bit drop counter.
module out_port_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 3
) (
  input  logic            clk,
  input  logic            reset,
  out_port_fifo_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              push_s, pop_s, drop_s, full_s, empty_s;
`ifdef OUT_PORT_FIFO_STATS_EN
  logic [15:0]       drop_cnt_q, drop_cnt_d;
`endif

  // full/empty come from the registered count only, so wr_en never reaches out_*
  assign full_s  = (count_q == CNT_W'(DEPTH));
  assign empty_s = (count_q == {CNT_W{1'b0}});

  always_comb begin
    pop_s      = ~empty_s & bus.out_ready;
    push_s     = bus.wr_en & (~full_s | pop_s);
    drop_s     = bus.wr_en & full_s & ~pop_s;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // a drop in the same cycle as clr_ovf keeps the sticky flag set
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (bus.clr_ovf) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

`ifdef OUT_PORT_FIFO_STATS_EN
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_s) begin
      if (bus.clr_ovf) begin
        drop_cnt_d = 16'd1;
      end else if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
    end else if (bus.clr_ovf) begin
      drop_cnt_d = 16'd0;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt_q <= 16'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus.drop_cnt = drop_cnt_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // storage needs no reset: entries are only visible while count is non-zero
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= bus.wr_data;
    end
  end

  assign bus.out_valid = ~empty_s;
  assign bus.out_data  = empty_s ? {DATA_W{1'b0}} : mem_q[rd_ptr_q];
  assign bus.full      = full_s;
  assign bus.empty     = empty_s;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_out_port_fifo.sv
// Randomised scoreboard bench for out_port_fifo against a queue-based reference model.
module tb_out_port_fifo;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  out_port_fifo_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();
  out_port_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int          tests = 0;
  int          fails = 0;
  logic [31:0] sb[$];
  int          model_cnt = 0;
  logic        model_ovf = 1'b0;
  int          model_drops = 0;
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model decides the outcome from the spec rules.
  task automatic step(input logic wr, input logic [31:0] d, input logic rdy, input logic clr);
    bit full_m, pop_m, push_m, drop_m;
    int nxt_cnt;
    bus.wr_en = wr; bus.wr_data = d; bus.out_ready = rdy; bus.clr_ovf = clr;
    full_m = (model_cnt == DEPTH);
    pop_m  = (model_cnt != 0) && rdy;
    push_m = wr && (!full_m || pop_m);
    drop_m = wr && full_m && !pop_m;
    if (push_m) sb.push_back(d);
    nxt_cnt = model_cnt + (push_m ? 1 : 0) - (pop_m ? 1 : 0);
    @(posedge clk); #1;
    model_cnt = nxt_cnt;
    if (drop_m) model_ovf = 1'b1;
    else if (clr) model_ovf = 1'b0;
    if (drop_m) model_drops = clr ? 1 : ((model_drops < 65535) ? model_drops + 1 : 65535);
    else if (clr) model_drops = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.wr_en = 1'b1; bus.wr_data = $urandom; bus.out_ready = 1'b1; bus.clr_ovf = 1'b0;
    sb.delete();
    model_cnt = 0; model_ovf = 1'b0; model_drops = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    bus.wr_en = 1'b0;
  endtask

  // Monitor: compares status against the model and pops the scoreboard on each handshake.
  always @(negedge clk) begin
    if (mon_en) begin
      check("count", 32'(bus.count), 32'(model_cnt));
      check("valid", 32'(bus.out_valid), 32'(model_cnt != 0));
      check("empty", 32'(bus.empty), 32'(model_cnt == 0));
      check("full", 32'(bus.full), 32'(model_cnt == DEPTH));
      check("overflow", 32'(bus.overflow), 32'(model_ovf));
`ifdef OUT_PORT_FIFO_STATS_EN
      check("drop_cnt", 32'(bus.drop_cnt), 32'(model_drops));
`endif
      if (!bus.out_valid) begin
        check("data_when_empty", bus.out_data, 32'h0);
      end else if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL head: got %0h expected no word at %0t", bus.out_data, $time);
      end else begin
        check("head", bus.out_data, sb[0]);
        if (bus.out_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b0;
    bus.wr_en = 1'b1; bus.wr_data = 32'hDEAD_BEEF; bus.out_ready = 1'b0; bus.clr_ovf = 1'b0;
    #12;
    check("rst_count", 32'(bus.count), 32'h0);
    check("rst_empty", 32'(bus.empty), 32'h1);
    check("rst_valid", 32'(bus.out_valid), 32'h0);
    check("rst_data", bus.out_data, 32'h0);
    mon_en = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1; bus.wr_en = 1'b0;
    @(posedge clk); #1;

    // three writes, consumer stalled
    step(1'b1, 32'h11, 1'b0, 1'b0);
    check("fwft_valid", 32'(bus.out_valid), 32'h1);
    check("fwft_data", bus.out_data, 32'h11);
    step(1'b1, 32'h22, 1'b0, 1'b0);
    step(1'b1, 32'h33, 1'b0, 1'b0);
    check("cnt3", 32'(bus.count), 32'd3);
    repeat (4) step(1'b0, 32'h0, 1'b1, 1'b0);

    // fill, then drop one
    for (int i = 0; i < 4; i++) step(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0);
    step(1'b1, 32'hFF, 1'b0, 1'b0);
    check("fill_full", 32'(bus.full), 32'h1);
    check("fill_ovf", 32'(bus.overflow), 32'h1);
    repeat (5) step(1'b0, 32'h0, 1'b1, 1'b0);
    check("drained", 32'(bus.count), 32'h0);

    // full with simultaneous write and pop
    for (int i = 0; i < 4; i++) step(1'b1, 32'hC0 + 32'(i), 1'b0, 1'b0);
    step(1'b1, 32'hBB, 1'b1, 1'b0);
    check("full_wr_pop", 32'(bus.count), 32'd4);
    repeat (3) step(1'b0, 32'h0, 1'b1, 1'b0);
    check("last_bb", bus.out_data, 32'hBB);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // interleaved writes and pops across pointer wrap
    for (int i = 0; i < 10; i++) step(1'b1, 32'h100 + 32'(i), (i % 3) != 0, 1'b0);
    repeat (5) step(1'b0, 32'h0, 1'b1, 1'b0);

    // clr_ovf coinciding with a drop, then alone
    for (int i = 0; i < 5; i++) step(1'b1, 32'hE0 + 32'(i), 1'b0, 1'b0);
    step(1'b1, 32'hEE, 1'b0, 1'b1);
    check("clr_vs_drop", 32'(bus.overflow), 32'h1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    check("clr_alone", 32'(bus.overflow), 32'h0);

    // reset while holding data
    do_reset();
    check("midrst_count", 32'(bus.count), 32'h0);

    // randomised traffic with varying consumer speed
    for (int ph = 0; ph < 4; ph++) begin
      for (int n = 0; n < 400; n++) begin
        if ($urandom_range(0, 199) == 0) do_reset();
        else step($urandom_range(0, 3) != 0, $urandom,
                  $urandom_range(0, 3) < ph + 1 - (ph == 3 ? 2 : 0), $urandom_range(0, 15) == 0);
      end
    end
    repeat (6) step(1'b0, 32'h0, 1'b1, 1'b0);
    check("final_empty", 32'(sb.size()), 32'h0);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
